// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use scoreboard, decode-branch hazard,
// outstanding data-request tracking and an exception drain/redirect sequencer.
module hazard_ctrl #(
  parameter int STAGES  = 5,
  parameter int ID_IDX  = 0,
  parameter int RW      = 5,
  parameter int MAX_OUT = 2,
  parameter int CW      = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [STAGES-1:0] stage_busy,
  input  logic              id_rs_ren,
  input  logic              id_rt_ren,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic              id_branch,
  input  logic              ex_regwen,
  input  logic [RW-1:0]     ex_wreg,
  input  logic              iss_fire,
  input  logic              iss_load,
  input  logic              iss_wen,
  input  logic [RW-1:0]     iss_wreg,
  input  logic              wb_load,
  input  logic [RW-1:0]     wb_wreg,
  input  logic              dreq_fire,
  input  logic              dresp,
  input  logic              exc_req,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              dreq_allow,
  output logic              dresp_discard,
  output logic              redirect,
  output logic [CW-1:0]     out_cnt
);

  // state | meaning
  // RUN   | normal issue, hazards and busy requests drive stall/flush
  // DRAIN | exception taken, waiting for outstanding loads to return
  // REDIR | one cycle: fetch loads the exception/epc target
  typedef enum logic [1:0] {RUN, DRAIN, REDIR} state_t;

  localparam int              NREG  = 2 ** RW;
  localparam logic [CW-1:0]   MAX_C = CW'(MAX_OUT);
  localparam logic [CW-1:0]   ONE   = CW'(1);

  state_t            state;
  logic [NREG-1:0]   sb, sb_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              inc, dec, hazard, br_hit, sb_set;
  logic [STAGES-1:0] stall_run, flush_run;

  assign br_hit = id_branch & ex_regwen & (ex_wreg != '0) &
                  ((id_rs_ren & (ex_wreg == id_rs)) | (id_rt_ren & (ex_wreg == id_rt)));
  assign hazard = (id_rs_ren & sb[id_rs]) | (id_rt_ren & sb[id_rt]) | br_hit;

  assign sb_set = iss_fire & iss_load & iss_wen & (iss_wreg != '0);

  always_comb begin
    sb_nxt = sb;
    if (state == REDIR) begin
      sb_nxt = '0;
    end else begin
      if (wb_load) sb_nxt[wb_wreg] = 1'b0;
      if (sb_set)  sb_nxt[iss_wreg] = 1'b1;
    end
  end

  // A request alongside a response is legal even at the limit.
  assign dec = dresp & (out_cnt != '0);
  assign inc = dreq_fire & ((out_cnt < MAX_C) | dec);

  always_comb begin
    cnt_nxt = out_cnt;
    if (inc && !dec)      cnt_nxt = out_cnt + ONE;
    else if (dec && !inc) cnt_nxt = out_cnt - ONE;
  end

  always_comb begin
    logic acc;
    acc       = 1'b0;
    stall_run = '0;
    flush_run = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc          = acc | stage_busy[i];
      stall_run[i] = acc | (hazard & (i <= ID_IDX));
    end
    for (int i = 1; i < STAGES; i++) begin
      flush_run[i] = stall_run[i-1] & ~stall_run[i];
    end
  end

  always_comb begin
    if (state == RUN) begin
      stall = stall_run;
      flush = flush_run;
    end else begin
      stall = STAGES'(1);
      flush = '1;
    end
  end

  assign dreq_allow    = (out_cnt < MAX_C) & (state == RUN);
  assign dresp_discard = dresp & (state != RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb      <= '0;
      out_cnt <= '0;
    end else begin
      sb      <= sb_nxt;
      out_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= RUN;
      redirect <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          redirect <= 1'b0;
          if (exc_req) begin
            if (cnt_nxt == '0) begin
              state    <= REDIR;
              redirect <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt_nxt == '0) begin
            state    <= REDIR;
            redirect <= 1'b1;
          end
        end
        REDIR: begin
          state    <= RUN;
          redirect <= 1'b0;
        end
        default: begin
          state    <= RUN;
          redirect <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with default parameters (5 stages, decode at 0).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] stage_busy;
  logic       id_rs_ren, id_rt_ren;
  logic [4:0] id_rs, id_rt;
  logic       id_branch, ex_regwen;
  logic [4:0] ex_wreg;
  logic       iss_fire, iss_load, iss_wen;
  logic [4:0] iss_wreg;
  logic       wb_load;
  logic [4:0] wb_wreg;
  logic       dreq_fire, dresp, exc_req;
  logic [4:0] stall, flush;
  logic       dreq_allow, dresp_discard, redirect;
  logic [1:0] out_cnt;

  int n_chk = 0;
  int n_err = 0;

  hazard_ctrl dut (
    .clk(clk), .resetn(resetn), .stage_busy(stage_busy),
    .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren), .id_rs(id_rs), .id_rt(id_rt),
    .id_branch(id_branch), .ex_regwen(ex_regwen), .ex_wreg(ex_wreg),
    .iss_fire(iss_fire), .iss_load(iss_load), .iss_wen(iss_wen), .iss_wreg(iss_wreg),
    .wb_load(wb_load), .wb_wreg(wb_wreg), .dreq_fire(dreq_fire), .dresp(dresp),
    .exc_req(exc_req), .stall(stall), .flush(flush), .dreq_allow(dreq_allow),
    .dresp_discard(dresp_discard), .redirect(redirect), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pipe(input string tag, input logic [4:0] s, input logic [4:0] f);
    #1;
    chk({tag, "_stall"}, 32'(stall), 32'(s));
    chk({tag, "_flush"}, 32'(flush), 32'(f));
  endtask

  task automatic issue_load(input logic [4:0] r);
    iss_fire = 1; iss_load = 1; iss_wen = 1; iss_wreg = r;
    tick();
    iss_fire = 0; iss_load = 0; iss_wen = 0; iss_wreg = 0;
  endtask

  initial begin
    resetn = 0; stage_busy = 0; id_rs_ren = 0; id_rt_ren = 0; id_rs = 0; id_rt = 0;
    id_branch = 0; ex_regwen = 0; ex_wreg = 0; iss_fire = 0; iss_load = 0; iss_wen = 0;
    iss_wreg = 0; wb_load = 0; wb_wreg = 0; dreq_fire = 0; dresp = 0; exc_req = 0;

    repeat (2) @(posedge clk);
    #1;
    chk_pipe("rst", 5'b00000, 5'b00000);
    chk("rst_allow", 32'(dreq_allow), 1);
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_cnt", 32'(out_cnt), 0);
    resetn = 1;
    tick();

    // load-use on rs
    issue_load(5'd5);
    id_rs_ren = 1; id_rs = 5;
    chk_pipe("lu1", 5'b00001, 5'b00010);
    tick();
    chk_pipe("lu2", 5'b00001, 5'b00010);
    id_rs_ren = 0;
    chk_pipe("lu_noren", 5'b00000, 5'b00000);
    id_rs_ren = 1; wb_load = 1; wb_wreg = 5;
    chk_pipe("lu_wb", 5'b00001, 5'b00010);
    tick();
    wb_load = 0; wb_wreg = 0;
    chk_pipe("lu_rel", 5'b00000, 5'b00000);
    id_rs_ren = 0; id_rs = 0;

    // same-cycle set and clear of r9: set wins; checked via rt
    iss_fire = 1; iss_load = 1; iss_wen = 1; iss_wreg = 9; wb_load = 1; wb_wreg = 9;
    tick();
    iss_fire = 0; iss_load = 0; iss_wen = 0; iss_wreg = 0; wb_load = 0; wb_wreg = 0;
    id_rt_ren = 1; id_rt = 9;
    chk_pipe("setwins", 5'b00001, 5'b00010);
    wb_load = 1; wb_wreg = 9;
    tick();
    wb_load = 0; wb_wreg = 0;
    chk_pipe("rt_rel", 5'b00000, 5'b00000);
    id_rt_ren = 0; id_rt = 0;

    // load to r0 never marks the scoreboard
    issue_load(5'd0);
    id_rs_ren = 1; id_rs = 0;
    chk_pipe("r0_load", 5'b00000, 5'b00000);

    // branch hazards against the instruction in execute
    id_branch = 1; id_rs = 3; ex_regwen = 1; ex_wreg = 3;
    chk_pipe("br_rs", 5'b00001, 5'b00010);
    tick();
    ex_regwen = 0;
    chk_pipe("br_rel", 5'b00000, 5'b00000);
    ex_regwen = 1; ex_wreg = 0; id_rs = 0;
    chk_pipe("br_r0", 5'b00000, 5'b00000);
    id_rs_ren = 0; id_rt_ren = 1; id_rt = 4; ex_wreg = 4;
    chk_pipe("br_rt", 5'b00001, 5'b00010);
    id_branch = 0;
    chk_pipe("nobranch", 5'b00000, 5'b00000);
    id_rt_ren = 0; id_rt = 0; ex_regwen = 0; ex_wreg = 0;

    // scoreboard r7 so its clearing by the exception can be observed
    issue_load(5'd7);
    id_rs_ren = 1; id_rs = 7;
    chk_pipe("sb7", 5'b00001, 5'b00010);
    id_rs_ren = 0;

    // outstanding requests
    dreq_fire = 1;
    tick();
    chk("cnt1", 32'(out_cnt), 1);
    chk("allow1", 32'(dreq_allow), 1);
    tick();
    dreq_fire = 0;
    chk("cnt2", 32'(out_cnt), 2);
    chk("allow2", 32'(dreq_allow), 0);
    dreq_fire = 1; dresp = 1;
    tick();
    dreq_fire = 0; dresp = 0;
    chk("cnt_both", 32'(out_cnt), 2);

    // exception with two loads in flight
    exc_req = 1;
    tick();
    exc_req = 0;
    chk_pipe("drain", 5'b00001, 5'b11111);
    chk("drain_allow", 32'(dreq_allow), 0);
    chk("drain_redir", 32'(redirect), 0);
    dresp = 1;
    #1 chk("discard1", 32'(dresp_discard), 1);
    tick();
    chk("drain_cnt1", 32'(out_cnt), 1);
    chk("drain_redir1", 32'(redirect), 0);
    chk("discard2", 32'(dresp_discard), 1);
    tick();
    dresp = 0;
    chk("redir", 32'(redirect), 1);
    chk("redir_cnt", 32'(out_cnt), 0);
    chk_pipe("redir", 5'b00001, 5'b11111);
    tick();
    chk("redir_end", 32'(redirect), 0);
    chk("run_allow", 32'(dreq_allow), 1);
    id_rs_ren = 1; id_rs = 7;
    chk_pipe("sb_clear", 5'b00000, 5'b00000);
    id_rs_ren = 0; id_rs = 0;
    dresp = 1;
    #1 chk("run_nodiscard", 32'(dresp_discard), 0);
    tick();
    dresp = 0;
    chk("cnt_floor", 32'(out_cnt), 0);

    // busy stage 3 holds everything upstream
    stage_busy = 5'b01000;
    for (int c = 0; c < 3; c++) begin
      chk_pipe("busy3", 5'b01111, 5'b10000);
      tick();
    end
    stage_busy = 0;
    tick();
    chk_pipe("busy_rel", 5'b00000, 5'b00000);

    // exception with no requests outstanding goes straight to redirect
    exc_req = 1;
    tick();
    exc_req = 0;
    chk("direct_redir", 32'(redirect), 1);
    tick();
    chk("direct_end", 32'(redirect), 0);

    // asynchronous reset in the middle of a drain
    dreq_fire = 1;
    tick();
    dreq_fire = 0; exc_req = 1;
    tick();
    exc_req = 0;
    chk("pre_cnt", 32'(out_cnt), 1);
    chk_pipe("pre_rst", 5'b00001, 5'b11111);
    #2 resetn = 0;
    #1;
    chk_pipe("async_rst", 5'b00000, 5'b00000);
    chk("async_cnt", 32'(out_cnt), 0);
    chk("async_allow", 32'(dreq_allow), 1);
    tick();
    resetn = 1;
    for (int c = 0; c < 4; c++) begin
      chk("no_redir", 32'(redirect), 0);
      tick();
    end
    chk_pipe("post_rst", 5'b00000, 5'b00000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline stall/flush controller, successor to the fixed 5-stage control unit. Generalises to STAGES pipeline registers with per-stage busy requests, and uses a register scoreboard for load-use and branch hazards. Tracks outstanding data-bus requests with a bounded counter. An exception/eret sequencer drains in-flight loads before redirecting fetch. Sits beside the datapath and drives every pipeline register's stall and flush.

Parameters:
STAGES, 5, number of pipeline registers; index 0 = IF/ID, STAGES-1 = last register before WB
ID_IDX, 0, register index whose output stage is decode (hazard check point)
RW, 5, register-address width; scoreboard depth = 2**RW
MAX_OUT, 2, maximum outstanding data requests
CW, 2, outstanding-counter width, must satisfy 2**CW > MAX_OUT

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
stage_busy  in  STAGES  bit i: stage after register i cannot advance (miss, div/mul)
id_rs_ren, id_rt_ren  in  1  decode reads rs/rt
id_rs, id_rt  in  RW  decode source registers
id_branch  in  1  decode holds a branch resolved in decode
ex_regwen  in  1  instruction after decode writes a register
ex_wreg  in  RW  its destination
iss_fire  in  1  decode instruction advances this cycle
iss_load, iss_wen  in  1  that instruction is a load / writes a register
iss_wreg  in  RW  its destination
wb_load  in  1  load result written back this cycle
wb_wreg  in  RW  its destination
dreq_fire  in  1  data request accepted (req & addr_ok)
dresp  in  1  data response (data_ok)
exc_req  in  1  exception or eret committed
stall  out  STAGES  hold register i
flush  out  STAGES  load bubble into register i
dreq_allow  out  1  data request may be issued
dresp_discard  out  1  current response belongs to a squashed load
redirect  out  1  one-cycle pulse; fetch loads exception/epc target
out_cnt  out  CW  outstanding requests

Behaviour:
- Reset (async, resetn=0): scoreboard all 0, out_cnt=0, state RUN, redirect=0. Combinational outputs follow from that state: stall=0, flush=0, dreq_allow=1.
- Scoreboard: bit r set at clk when iss_fire & iss_load & iss_wen & iss_wreg!=0. Bit cleared when wb_load & wb_wreg==r. Set and clear of same r in same cycle: set wins. Register 0 is never set.
- hazard = (id_rs_ren & sb[id_rs]) | (id_rt_ren & sb[id_rt]) | (id_branch & ex_regwen & ex_wreg!=0 & (id_rs_ren&ex_wreg==id_rs | id_rt_ren&ex_wreg==id_rt)).
- dreq_allow = (out_cnt < MAX_OUT) & state==RUN. The stage owning the memory port treats !dreq_allow as busy.
- stall[i] = OR(stage_busy[STAGES-1:i]) | (i<=ID_IDX & hazard) | (state!=RUN & i==0).
- flush[i] (i>=1) = stall[i-1] & !stall[i] (bubble behind a held register). flush[0]=0 in RUN.
- Counter: +1 on dreq_fire, -1 on dresp, unchanged when both occur. dresp at 0 is ignored. dreq_fire at MAX_OUT is impossible (dreq_allow=0); the counter holds.
- FSM RUN -> exc_req: out_cnt==0 (after this cycle's dresp) ? REDIR : DRAIN. DRAIN -> REDIR when the counter reaches 0. REDIR -> RUN after one cycle.
- DRAIN and REDIR: flush all STAGES bits=1, stall=0 except stall[0], dresp_discard=1 on every dresp.
- REDIR: redirect=1; scoreboard cleared entirely at the end of REDIR.
- exc_req while in DRAIN/REDIR is ignored. exc_req has priority over hazard.
- Reset mid-DRAIN returns directly to RUN with counter 0.

Test Plan:
- Load to r5 issued (iss_fire, iss_load, iss_wreg=5), next decode reads rs=5 -> stall[0..ID_IDX]=1, flush[ID_IDX+1]=1 each cycle until wb_load with wb_wreg=5; released the cycle after.
- id_branch rs=3 with ex_regwen ex_wreg=3 -> stall[0]=1 for one cycle. Same case with ex_wreg=0 -> no stall.
- MAX_OUT=2: two dreq_fire with no dresp -> out_cnt=2, dreq_allow=0. Simultaneous dresp+dreq_fire -> out_cnt stays 2 (allowed after a dresp).
- exc_req with out_cnt=2 -> DRAIN, flush=all 1s. Two dresp each with dresp_discard=1. Then redirect pulses once and the scoreboard is empty.
- stage_busy[3]=1 for 3 cycles -> stall[0..3]=1, flush[4]=1, stall[4]=0. Deassert -> all zero next cycle.
- resetn low during DRAIN with out_cnt=1 -> outputs at reset values immediately (async); redirect never asserted.
